// File: rtl/parser_rule_loader.sv
`default_nettype none
// ============================================================================
// Module      : parser_rule_loader
// Description : Configuration initiator for the Parser_Top rule port. Takes
//               (addr, wdata, mask, verify) commands over valid/ready, issues
//               one rule write per command, optionally reads the location
//               back and compares it under a mask, then reports a completion
//               code and updates saturating write/error counters.
// Ports       : i_clk, i_rst (async, active-high)
//               i_cmd_*  / o_cmd_ready     : command handshake from host
//               o_rule_* / i_rule_rdata*   : rule port towards the parser
//               o_done_valid, o_done_code  : per-command status pulse
//               o_busy                     : FSM outside IDLE
//               i_cnt_clr, o_wr_cnt, o_err_cnt : status counters
// Revision    : 1.0 - initial release
// ============================================================================
module parser_rule_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_TIMEOUT = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [DATA_WIDTH-1:0] i_cmd_mask,
    input  logic                  i_cmd_verify,
    output logic                  o_rule_wren,
    output logic                  o_rule_rden,
    output logic [ADDR_WIDTH-1:0] o_rule_addr,
    output logic [DATA_WIDTH-1:0] o_rule_wdata,
    input  logic                  i_rule_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_rule_rdata,
    output logic                  o_done_valid,
    output logic [1:0]            o_done_code,
    output logic                  o_busy,
    input  logic                  i_cnt_clr,
    output logic [CNT_WIDTH-1:0]  o_wr_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);

    localparam int              TMR_W       = $clog2(RD_TIMEOUT);
    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(RD_TIMEOUT - 1);
    localparam logic [1:0]      c_code_ok   = 2'd0;
    localparam logic [1:0]      c_code_mism = 2'd1;
    localparam logic [1:0]      c_code_tout = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_WAIT   = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_mask;
    logic                  r_verify;
    logic [TMR_W-1:0]      r_tmr;
    logic [1:0]            r_code;
    logic [CNT_WIDTH-1:0]  r_wr_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;
    logic                  w_accept;
    logic                  w_code_ld;
    logic [1:0]            w_code_nxt;
    logic                  w_mismatch;

    // Only bits selected by the mask take part in the readback compare.
    assign w_mismatch = |((i_rule_rdata ^ r_wdata) & r_mask);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_code_ld    = 1'b0;
        w_code_nxt   = c_code_ok;
        o_rule_wren  = 1'b0;
        o_rule_rden  = 1'b0;
        o_done_valid = 1'b0;
        o_done_code  = 2'd0;
        o_busy       = 1'b1;
        o_rule_addr  = r_addr;
        o_rule_wdata = r_wdata;
        case (r_state)
            S_IDLE: begin
                o_busy       = 1'b0;
                o_rule_addr  = '0;
                o_rule_wdata = '0;
                if (i_cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                o_rule_wren = 1'b1;
                if (r_verify) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_REPORT;
                    w_code_ld   = 1'b1;
                end
            end
            S_READ: begin
                o_rule_rden = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Read data arriving on the final timer cycle beats the timeout.
                if (i_rule_rdata_valid) begin
                    w_state_nxt = S_REPORT;
                    w_code_ld   = 1'b1;
                    w_code_nxt  = w_mismatch ? c_code_mism : c_code_ok;
                end else if (r_tmr == c_tmr_last) begin
                    w_state_nxt = S_REPORT;
                    w_code_ld   = 1'b1;
                    w_code_nxt  = c_code_tout;
                end
            end
            S_REPORT: begin
                o_done_valid = 1'b1;
                o_done_code  = r_code;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ready depends on registered state only; held low while reset is applied.
    assign o_cmd_ready = (r_state == S_IDLE) && !i_rst;

    // ------------------------------------------------------------------
    // Command capture, read timer and completion code
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_mask   <= '0;
            r_verify <= 1'b0;
            r_tmr    <= '0;
            r_code   <= 2'd0;
        end else begin
            if (w_accept) begin
                r_addr   <= i_cmd_addr;
                r_wdata  <= i_cmd_wdata;
                r_mask   <= i_cmd_mask;
                r_verify <= i_cmd_verify;
            end
            if (r_state == S_READ) begin
                r_tmr <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmr <= r_tmr + 1'b1;
            end
            if (w_code_ld) begin
                r_code <= w_code_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating status counters; clear wins over a same-cycle increment.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_wr_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (r_state == S_REPORT) begin
            if (r_wr_cnt != '1) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if ((r_code != c_code_ok) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_wr_cnt  = r_wr_cnt;
    assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire
